// File: rtl/mem_stage_wb.sv
// Memory-access stage and MEM/WB pipeline register: issues loads/stores over a
// req/ack data-memory port, stalls upstream while busy, and registers the writeback result.
module mem_stage_wb #(
   parameter int unsigned MAX_WAIT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        regwrite_m,
   input  logic        memwrite_m,
   input  logic [1:0]  memtoreg_m,
   input  logic [31:0] aluout_m,
   input  logic [31:0] writedata_m,
   input  logic [4:0]  writereg_m,
   input  logic [31:0] pcplus4_m,
   output logic        stall_m,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic        regwrite_w,
   output logic [4:0]  writereg_w,
   output logic [31:0] result_w,
   output logic        mem_err
);

   localparam int unsigned CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

   localparam logic [1:0] SEL_ALU  = 2'b00;
   localparam logic [1:0] SEL_LOAD = 2'b01;
   localparam logic [1:0] SEL_LINK = 2'b10;

   typedef enum logic [0:0] {
      S_IDLE   = 1'b0,
      S_ACCESS = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              req_d, we_d, regwrite_d, err_d;
   logic [31:0]       addr_d, wdata_d, result_d;
   logic [4:0]        writereg_d;

   logic              is_load_c, mem_op_c, misaligned_c, timeout_c;
   logic [31:0]       alu_result_c;

   assign is_load_c    = (memtoreg_m == SEL_LOAD);
   assign mem_op_c     = memwrite_m | is_load_c;
   assign misaligned_c = (aluout_m[1:0] != 2'b00);
   assign timeout_c    = (cnt_q == CNT_LAST);
   // Reserved select 11 behaves like the ALU path.
   assign alu_result_c = (memtoreg_m == SEL_LINK) ? pcplus4_m : aluout_m;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (mem_op_c && !misaligned_c) begin
               state_d = S_ACCESS;
            end
         end
         S_ACCESS: begin
            if (dmem_ack || timeout_c) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Stall and next values of the registered outputs
   always_comb begin
      stall_m    = 1'b0;
      cnt_d      = cnt_q;
      req_d      = dmem_req;
      we_d       = dmem_we;
      addr_d     = dmem_addr;
      wdata_d    = dmem_wdata;
      regwrite_d = 1'b0;
      writereg_d = writereg_w;
      result_d   = result_w;
      err_d      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!mem_op_c) begin
               regwrite_d = regwrite_m;
               writereg_d = writereg_m;
               result_d   = alu_result_c;
            end else if (misaligned_c) begin
               err_d = 1'b1;
            end else begin
               stall_m = 1'b1;
               cnt_d   = '0;
               req_d   = 1'b1;
               we_d    = memwrite_m;
               addr_d  = aluout_m;
               wdata_d = writedata_m;
            end
         end
         S_ACCESS: begin
            if (dmem_ack) begin
               req_d      = 1'b0;
               regwrite_d = regwrite_m;
               writereg_d = writereg_m;
               result_d   = is_load_c ? dmem_rdata : aluout_m;
            end else if (timeout_c) begin
               req_d = 1'b0;
               err_d = 1'b1;
            end else begin
               stall_m = 1'b1;
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            req_d = 1'b0;
         end
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q      <= '0;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         regwrite_w <= 1'b0;
         writereg_w <= '0;
         result_w   <= '0;
         mem_err    <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         dmem_req   <= req_d;
         dmem_we    <= we_d;
         dmem_addr  <= addr_d;
         dmem_wdata <= wdata_d;
         regwrite_w <= regwrite_d;
         writereg_w <= writereg_d;
         result_w   <= result_d;
         mem_err    <= err_d;
      end
   end

endmodule

// File: tb/tb_mem_stage_wb.sv
// Directed bench for mem_stage_wb: expected writebacks are queued when an
// instruction is driven and checked when the stage releases it.
module tb_mem_stage_wb;

   localparam int unsigned MAX_WAIT = 16;

   logic        clk, reset;
   logic        regwrite_m, memwrite_m;
   logic [1:0]  memtoreg_m;
   logic [31:0] aluout_m, writedata_m, pcplus4_m;
   logic [4:0]  writereg_m;
   logic        stall_m, dmem_req, dmem_we, dmem_ack;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic        regwrite_w, mem_err;
   logic [4:0]  writereg_w;
   logic [31:0] result_w;

   typedef struct packed {
      logic        rw;
      logic [4:0]  wr;
      logic [31:0] res;
      logic        err;
   } exp_t;

   exp_t exp_q[$];
   int   nchk = 0;
   int   nerr = 0;
   logic [4:0]  m_wr;
   logic [31:0] m_res;

   mem_stage_wb #(.MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .reset(reset),
      .regwrite_m(regwrite_m), .memwrite_m(memwrite_m), .memtoreg_m(memtoreg_m),
      .aluout_m(aluout_m), .writedata_m(writedata_m), .writereg_m(writereg_m),
      .pcplus4_m(pcplus4_m), .stall_m(stall_m),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
      .regwrite_w(regwrite_w), .writereg_w(writereg_w), .result_w(result_w),
      .mem_err(mem_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_inputs(input logic rw, input logic mw, input logic [1:0] mtr,
                             input logic [31:0] alu, input logic [31:0] wd,
                             input logic [4:0] wr, input logic [31:0] pc4);
      regwrite_m = rw; memwrite_m = mw; memtoreg_m = mtr;
      aluout_m = alu; writedata_m = wd; writereg_m = wr; pcplus4_m = pc4;
   endtask

   // Drive one instruction, answer the memory after ack_delay request cycles
   // (negative = never), then check the writeback. Called at posedge+1.
   task automatic run_op(input string tag, input logic rw, input logic mw, input logic [1:0] mtr,
                         input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr,
                         input logic [31:0] pc4, input int ack_delay, input logic [31:0] rd);
      logic memop, mis, tmo, done, first;
      int   exp_stalls, stalls, req_cyc;
      exp_t e, got;
      memop = mw | (mtr == 2'b01);
      mis   = (alu[1:0] != 2'b00);
      tmo   = memop && !mis && (ack_delay < 0 || ack_delay >= int'(MAX_WAIT));
      if (!memop) begin
         e = '{rw: rw, wr: wr, res: (mtr == 2'b10) ? pc4 : alu, err: 1'b0};
         exp_stalls = 0;
      end else if (mis) begin
         e = '{rw: 1'b0, wr: m_wr, res: m_res, err: 1'b1};
         exp_stalls = 0;
      end else if (tmo) begin
         e = '{rw: 1'b0, wr: m_wr, res: m_res, err: 1'b1};
         exp_stalls = int'(MAX_WAIT);
      end else begin
         e = '{rw: rw, wr: wr, res: (mtr == 2'b01) ? rd : alu, err: 1'b0};
         exp_stalls = ack_delay + 1;
      end
      m_wr = e.wr; m_res = e.res;
      exp_q.push_back(e);
      set_inputs(rw, mw, mtr, alu, wd, wr, pc4);
      stalls = 0; req_cyc = 0; done = 1'b0; first = 1'b1;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         if (dmem_req) begin
            if (first) begin
               check({tag, ".we"},    32'(dmem_we), 32'(mw));
               check({tag, ".addr"},  dmem_addr, alu);
               if (mw) check({tag, ".wdata"}, dmem_wdata, wd);
               first = 1'b0;
            end
            if (req_cyc == ack_delay) begin
               dmem_ack = 1'b1; dmem_rdata = rd;
            end else begin
               check({tag, ".bubble"}, 32'(regwrite_w), 32'd0);
            end
            req_cyc++;
         end
         #1;
         if (stall_m) stalls++;
         else done = 1'b1;
         @(posedge clk); #1;
         dmem_ack = 1'b0; dmem_rdata = 32'hx;
      end
      if (!done) begin
         nchk++; nerr++;
         $error("FAIL %s.timeout: stall_m never released", tag);
      end
      check({tag, ".stalls"}, 32'(stalls), 32'(exp_stalls));
      if (memop && !mis) check({tag, ".req_drop"}, 32'(dmem_req), 32'd0);
      if (!memop || mis) check({tag, ".no_req"}, 32'(first), 32'd1);
      got = exp_q.pop_front();
      check({tag, ".regwrite_w"}, 32'(regwrite_w), 32'(got.rw));
      check({tag, ".writereg_w"}, 32'(writereg_w), 32'(got.wr));
      check({tag, ".result_w"},   result_w, got.res);
      check({tag, ".mem_err"},    32'(mem_err), 32'(got.err));
   endtask

   initial begin
      reset = 1'b1; dmem_ack = 1'b0; dmem_rdata = '0;
      set_inputs(1'b0, 1'b0, 2'b00, '0, '0, '0, '0);
      m_wr = '0; m_res = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst.dmem_req", 32'(dmem_req), 32'd0);
      check("rst.regwrite_w", 32'(regwrite_w), 32'd0);
      check("rst.result_w", result_w, 32'd0);
      check("rst.mem_err", 32'(mem_err), 32'd0);
      check("rst.stall_m", 32'(stall_m), 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      run_op("add",  1'b1, 1'b0, 2'b00, 32'h0000_0010, 32'h0, 5'd8, 32'h400, 0, 32'h0);
      run_op("lw",   1'b1, 1'b0, 2'b01, 32'h0000_0100, 32'h0, 5'd9, 32'h404, 2, 32'hDEAD_BEEF);
      run_op("sw",   1'b0, 1'b1, 2'b00, 32'h0000_0204, 32'h1234, 5'd3, 32'h408, 0, 32'h0);
      run_op("jal",  1'b1, 1'b0, 2'b10, 32'h0000_0777, 32'h0, 5'd31, 32'h0000_040C, 0, 32'h0);
      run_op("rsv",  1'b1, 1'b0, 2'b11, 32'hCAFE_0001, 32'h0, 5'd4, 32'h410, 0, 32'h0);
      run_op("mis",  1'b1, 1'b0, 2'b01, 32'h0000_0102, 32'h0, 5'd10, 32'h414, 0, 32'h0);
      run_op("lw0",  1'b1, 1'b0, 2'b01, 32'h0000_0300, 32'h0, 5'd11, 32'h418, 0, 32'h1357_9BDF);
      run_op("lw15", 1'b1, 1'b0, 2'b01, 32'h0000_0304, 32'h0, 5'd12, 32'h41C, 15, 32'h0BAD_F00D);
      run_op("tmo",  1'b1, 1'b0, 2'b01, 32'h0000_0308, 32'h0, 5'd13, 32'h420, -1, 32'h0);

      // Late ack while idle with a non-writing ALU op in M
      set_inputs(1'b0, 1'b0, 2'b00, 32'h55, 32'h0, 5'd1, 32'h0);
      dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      check("late_ack.req", 32'(dmem_req), 32'd0);
      check("late_ack.err", 32'(mem_err), 32'd0);
      check("late_ack.result", result_w, 32'h55);
      m_wr = 5'd1; m_res = 32'h55;
      run_op("add2", 1'b1, 1'b0, 2'b00, 32'h0000_0ABC, 32'h0, 5'd14, 32'h424, 0, 32'h0);

      // Reset in the middle of an access
      set_inputs(1'b1, 1'b0, 2'b01, 32'h0000_0500, 32'h0, 5'd15, 32'h428);
      @(posedge clk); #1;
      check("rst_mid.req_up", 32'(dmem_req), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("rst_mid.req", 32'(dmem_req), 32'd0);
      check("rst_mid.regwrite_w", 32'(regwrite_w), 32'd0);
      check("rst_mid.writereg_w", 32'(writereg_w), 32'd0);
      check("rst_mid.result_w", result_w, 32'd0);
      set_inputs(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 32'h0);
      @(negedge clk); reset = 1'b0;
      m_wr = '0; m_res = '0;
      dmem_ack = 1'b1; dmem_rdata = 32'h9999_9999;
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      check("rst_mid.idle_req", 32'(dmem_req), 32'd0);
      check("rst_mid.idle_stall", 32'(stall_m), 32'd0);
      run_op("add3", 1'b1, 1'b0, 2'b00, 32'h0000_0042, 32'h0, 5'd16, 32'h42C, 0, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
      $finish;
   end

endmodule
